// File: rtl/mux_chk_pkg.sv
// Shared types and default sizing for the 4:1 mux equivalence checker.
//   mux_chk_state_t : sweep FSM states
//   N_IN_DEFAULT    : vector width {a,b,c,d,s0,s1}
//   N_DUT_DEFAULT   : number of mux outputs compared
//   SETTLE_DEFAULT  : cycles between driving and sampling a vector
//   VEC_LAST        : last vector of a default-width sweep
package mux_chk_pkg;

    localparam int unsigned N_IN_DEFAULT   = 6;
    localparam int unsigned N_DUT_DEFAULT  = 3;
    localparam int unsigned SETTLE_DEFAULT = 1;
    localparam int unsigned VEC_LAST       = (1 << N_IN_DEFAULT) - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } mux_chk_state_t;

endpackage : mux_chk_pkg

// File: rtl/mux_chk_score.sv
// Scoreboard for one sweep: decides agreement of all mux outputs and keeps
// the match count plus the first disagreeing vector.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : clear all scores (start of a sweep)
//   en          : score the current y against the current vec
//   y           : mux outputs under test
//   vec         : vector currently applied
//   match_c     : combinational agreement of y (used by the FSM for pass)
//   match_cnt   : number of agreeing vectors so far
//   fail_seen   : at least one disagreement so far
//   first_fail  : first disagreeing vector, 0 if none
module mux_chk_score
    import mux_chk_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEFAULT,
    parameter int unsigned N_DUT = N_DUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [N_DUT-1:0]  y,
    input  logic [N_IN-1:0]   vec,
    output logic              match_c,
    output logic [N_IN:0]     match_cnt,
    output logic              fail_seen,
    output logic [N_IN-1:0]   first_fail
);

    logic [N_IN:0]   match_cnt_q,  match_cnt_d;
    logic            fail_seen_q,  fail_seen_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;

    // All-ones or all-zeros; case equality makes any X/Z bit a mismatch.
    always_comb begin
        match_c = (y === {N_DUT{1'b1}}) || (y === {N_DUT{1'b0}});
    end

    // Score update: clear wins over enable; only the first miss is latched.
    always_comb begin
        match_cnt_d  = match_cnt_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        if (clr) begin
            match_cnt_d  = '0;
            fail_seen_d  = 1'b0;
            first_fail_d = '0;
        end else if (en) begin
            if (match_c) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end else if (!fail_seen_q) begin
                fail_seen_d  = 1'b1;
                first_fail_d = vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_q  <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            match_cnt_q  <= match_cnt_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign match_cnt  = match_cnt_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;

endmodule : mux_chk_score

// File: rtl/mux_equiv_checker.sv
// Self-check engine for the 4:1 mux family: sweeps every input vector into
// the muxes, waits SETTLE cycles, then checks that all outputs agree.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a sweep (honoured in IDLE or DONE only)
//   vec         : vector {a,b,c,d,s0,s1} applied to every mux
//   y           : mux outputs, y[0] = y1
//   busy        : sweep in progress
//   done        : sweep finished, results valid
//   pass        : every vector agreed (valid with done)
//   match_cnt   : number of agreeing vectors
//   fail_seen   : at least one disagreement this sweep
//   first_fail  : first disagreeing vector, 0 if none
module mux_equiv_checker
    import mux_chk_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEFAULT,
    parameter int unsigned N_DUT  = N_DUT_DEFAULT,
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec,
    input  logic [N_DUT-1:0]  y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     match_cnt,
    output logic              fail_seen,
    output logic [N_IN-1:0]   first_fail
);

    localparam int unsigned    CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_MAX     = {N_IN{1'b1}};
    localparam logic [N_IN:0]    MATCH_LAST  = {1'b0, {N_IN{1'b1}}};

    mux_chk_state_t   state_q,  state_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [N_IN-1:0]  vec_q,    vec_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;

    logic             score_clr_c;
    logic             score_en_c;
    logic             match_c;

    // Next-state, settle/vector counters and registered status.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        vec_d       = vec_q;
        pass_d      = pass_q;
        score_clr_c = 1'b0;
        score_en_c  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    vec_d       = '0;
                    settle_d    = SETTLE_LOAD;
                    pass_d      = 1'b0;
                    score_clr_c = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (settle_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                score_en_c = 1'b1;
                if (vec_q == VEC_MAX) begin
                    state_d = ST_DONE;
                    // Full score only if all earlier vectors and this one agreed.
                    pass_d  = match_c && (match_cnt == MATCH_LAST);
                end else begin
                    state_d  = ST_DRIVE;
                    vec_d    = vec_q + 1'b1;
                    settle_d = SETTLE_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    mux_chk_score #(
        .N_IN  (N_IN),
        .N_DUT (N_DUT)
    ) u_score (
        .clk        (clk),
        .rst        (rst),
        .clr        (score_clr_c),
        .en         (score_en_c),
        .y          (y),
        .vec        (vec_q),
        .match_c    (match_c),
        .match_cnt  (match_cnt),
        .fail_seen  (fail_seen),
        .first_fail (first_fail)
    );

    assign vec  = vec_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule : mux_equiv_checker

// File: tb/tb_mux_equiv_checker.sv
// Bench for mux_equiv_checker: two instances (SETTLE=1 and SETTLE=3) driven by
// a behavioural 4:1 mux with per-vector fault masks; results are predicted
// from the fault table and the sweep timing rules.
module tb_mux_equiv_checker;

    localparam int N_IN  = 6;
    localparam int N_DUT = 3;
    localparam int NVEC  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start1, start3;

    logic [N_IN-1:0]  vec1, vec3, first_fail1, first_fail3;
    logic [N_DUT-1:0] y1, y3;
    logic             busy1, busy3, done1, done3, pass1, pass3;
    logic             fail_seen1, fail_seen3;
    logic [N_IN:0]    match_cnt1, match_cnt3;

    logic [N_DUT-1:0] fault_mask [NVEC];

    int n_checks = 0;
    int n_errors = 0;

    mux_equiv_checker #(.N_IN(N_IN), .N_DUT(N_DUT), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec(vec1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .match_cnt(match_cnt1),
        .fail_seen(fail_seen1), .first_fail(first_fail1)
    );

    mux_equiv_checker #(.N_IN(N_IN), .N_DUT(N_DUT), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .vec(vec3), .y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .match_cnt(match_cnt3),
        .fail_seen(fail_seen3), .first_fail(first_fail3)
    );

    // Reference 4:1 mux: v = {a,b,c,d,s0,s1}, select = {s1,s0}.
    function automatic logic ref_mux(input logic [5:0] v);
        case ({v[0], v[1]})
            2'd0:    return v[5];
            2'd1:    return v[4];
            2'd2:    return v[3];
            default: return v[2];
        endcase
    endfunction

    function automatic logic [N_DUT-1:0] mux_outputs(input logic [5:0] v);
        return {N_DUT{ref_mux(v)}} ^ fault_mask[v];
    endfunction

    always_comb y1 = mux_outputs(vec1);
    always_comb y3 = mux_outputs(vec3);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Prediction: vector agrees when every output shows the same value.
    task automatic predict(output int exp_match, output int exp_first, output bit exp_fail);
        int ones;
        exp_match = 0;
        exp_first = 0;
        exp_fail  = 1'b0;
        for (int v = 0; v < NVEC; v++) begin
            ones = $countones(mux_outputs(6'(v)));
            if (ones == 0 || ones == N_DUT) exp_match++;
            else if (!exp_fail) begin
                exp_fail  = 1'b1;
                exp_first = v;
            end
        end
    endtask

    function automatic logic [N_IN-1:0] cur_vec(input bit use3);
        return use3 ? vec3 : vec1;
    endfunction
    function automatic logic cur_busy(input bit use3);
        return use3 ? busy3 : busy1;
    endfunction
    function automatic logic cur_done(input bit use3);
        return use3 ? done3 : done1;
    endfunction

    task automatic set_start(input bit use3, input logic val);
        if (use3) start3 = val;
        else      start1 = val;
    endtask

    // One sweep: start, track vec timing every cycle, then check results.
    task automatic run_sweep(input bit use3, input int mid_start_t, input string name);
        int period, t, exp_match, exp_first, limit;
        bit exp_fail;
        period = use3 ? 4 : 2;
        limit  = NVEC * period + 20;
        predict(exp_match, exp_first, exp_fail);

        @(negedge clk);
        set_start(use3, 1'b1);
        @(negedge clk);
        set_start(use3, 1'b0);
        t = 0;
        check_eq({name, "_start_done_low"}, 32'(cur_done(use3)), 0);
        check_eq({name, "_start_cnt_clr"}, 32'(use3 ? match_cnt3 : match_cnt1), 0);
        check_eq({name, "_start_fseen_clr"}, 32'(use3 ? fail_seen3 : fail_seen1), 0);
        check_eq({name, "_start_ffail_clr"}, 32'(use3 ? first_fail3 : first_fail1), 0);

        while (!cur_done(use3) && t < limit) begin
            check_eq({name, "_vec"}, 32'(cur_vec(use3)), 32'(t / period));
            check_eq({name, "_busy"}, 32'(cur_busy(use3)), 1);
            if (t == mid_start_t) set_start(use3, 1'b1);
            @(negedge clk);
            set_start(use3, 1'b0);
            t++;
        end

        check_eq({name, "_done_cycle"}, 32'(t), 32'(NVEC * period));
        check_eq({name, "_done"}, 32'(cur_done(use3)), 1);
        check_eq({name, "_busy_end"}, 32'(cur_busy(use3)), 0);
        check_eq({name, "_vec_end"}, 32'(cur_vec(use3)), NVEC - 1);
        check_eq({name, "_pass"}, 32'(use3 ? pass3 : pass1), 32'(exp_match == NVEC));
        check_eq({name, "_match_cnt"}, 32'(use3 ? match_cnt3 : match_cnt1), 32'(exp_match));
        check_eq({name, "_fail_seen"}, 32'(use3 ? fail_seen3 : fail_seen1), 32'(exp_fail));
        check_eq({name, "_first_fail"}, 32'(use3 ? first_fail3 : first_fail1), 32'(exp_first));
    endtask

    task automatic clear_faults();
        for (int v = 0; v < NVEC; v++) fault_mask[v] = '0;
    endtask

    task automatic check_dut1_reset(input string name);
        check_eq({name, "_vec"}, 32'(vec1), 0);
        check_eq({name, "_busy"}, 32'(busy1), 0);
        check_eq({name, "_done"}, 32'(done1), 0);
        check_eq({name, "_pass"}, 32'(pass1), 0);
        check_eq({name, "_match_cnt"}, 32'(match_cnt1), 0);
        check_eq({name, "_fail_seen"}, 32'(fail_seen1), 0);
        check_eq({name, "_first_fail"}, 32'(first_fail1), 0);
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_dut1_reset("reset");
        check_eq("reset3_busy", 32'(busy3), 0);
        check_eq("reset3_done", 32'(done3), 0);

        // Clean sweep with an ignored start pulse in the middle.
        run_sweep(1'b0, 40, "clean");

        // y[2] permanently inverted; restart straight from DONE.
        for (int v = 0; v < NVEC; v++) fault_mask[v] = 3'b100;
        run_sweep(1'b0, -1, "inv_y2");

        clear_faults();
        fault_mask[37] = 3'b010;
        run_sweep(1'b0, -1, "fault37");

        clear_faults();
        fault_mask[12] = 3'b001;
        fault_mask[50] = 3'b110;
        run_sweep(1'b0, 7, "fault12_50");

        // Reset mid-sweep, with a start in the same cycle that must be ignored.
        clear_faults();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("midrst_busy_before", 32'(busy1), 1);
        rst    = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start1 = 1'b0;
        check_dut1_reset("midrst");
        @(negedge clk);
        check_eq("midrst_idle_busy", 32'(busy1), 0);
        run_sweep(1'b0, -1, "after_rst");

        // Randomized fault tables; an all-ones mask still agrees.
        for (int it = 0; it < 6; it++) begin
            for (int v = 0; v < NVEC; v++) begin
                if ($urandom_range(0, 7) == 0) fault_mask[v] = 3'($urandom_range(1, 7));
                else                           fault_mask[v] = '0;
            end
            run_sweep(1'b0, int'($urandom_range(0, 127)), "rand");
        end

        // Longer settle time.
        clear_faults();
        fault_mask[5] = 3'b001;
        run_sweep(1'b1, 100, "settle3_f5");
        clear_faults();
        run_sweep(1'b1, -1, "settle3_clean");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mux_equiv_checker
